tnn_csr_encoder: RTL and testbench

Converts dense ternary weight rows into the compressed-sparse-row stream consumed by the sparse ternary inference cores: per-nonzero sign bits, column indices, and cumulative row pointers. It is the encoding end of the CSR weight format. It sits between a dense weight source (training export, on-chip weight update, or bench) and the loader that builds the `SPARSE_VALS2` / `COL_INDICES` / `ROW_PTRS` images. One row is accepted at a time, scanned, and its nonzeros are emitted under valid/ready back-pressure.

---
 rtl/tnn_csr_encoder.sv | 145 ++++++++++++++
 tb/tb_tnn_csr_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_csr_encoder.sv
// tnn_csr_encoder: turns dense ternary weight rows into a CSR stream of
// (column, sign) entries plus one cumulative end pointer per row.
// Optional build macro TNN_CSR_SKIP_EN: jump straight to the next nonzero
// column instead of walking every column; emitted values are identical.
module tnn_csr_encoder #(
    parameter int COL_CNT = 40,
    parameter int ROW_CNT = 6,
    parameter int CW = $clog2(COL_CNT),
    parameter int PW = $clog2(ROW_CNT * COL_CNT + 1),
    localparam int RW = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [COL_CNT-1:0] row_mask,
    input  logic [COL_CNT-1:0] row_sign,
    output logic               ent_valid,
    input  logic               ent_ready,
    output logic [CW-1:0]      ent_col,
    output logic               ent_sign,
    output logic               ent_last,
    output logic               ptr_valid,
    output logic [PW-1:0]      ptr_value,
    output logic [RW-1:0]      ptr_row,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SCAN, PTR} state_t;

    state_t             state_q, state_d;
    logic [COL_CNT-1:0] mask_q, mask_d;
    logic [COL_CNT-1:0] sign_q, sign_d;
    logic [RW-1:0]      row_idx_q, row_idx_d;
    logic [PW-1:0]      nnz_total_q, nnz_total_d;
    logic [CW-1:0]      cur_col;
    logic               cur_last;
    logic               ent_hs;

`ifdef TNN_CSR_SKIP_EN
    // mask_q doubles as the remaining-nonzero set; present its lowest set bit
    always_comb begin
        cur_col = '0;
        for (int c = COL_CNT - 1; c >= 0; c--) begin
            if (mask_q[c]) cur_col = CW'(c);
        end
        cur_last = (mask_q != '0) && ((mask_q & (mask_q - COL_CNT'(1))) == '0);
    end
`else
    logic [CW-1:0] col_q, col_d;
    logic          has_above;

    // Present the current column and note whether any nonzero lies beyond it
    always_comb begin
        cur_col   = col_q;
        has_above = 1'b0;
        for (int c = 0; c < COL_CNT; c++) begin
            if (c > int'(col_q) && mask_q[c]) has_above = 1'b1;
        end
        cur_last = !has_above;
    end
`endif

    assign row_ready = (state_q == IDLE);
    assign ent_valid = (state_q == SCAN) && mask_q[cur_col];
    assign ent_col   = cur_col;
    assign ent_sign  = sign_q[cur_col];
    assign ent_last  = ent_valid && cur_last;
    assign ent_hs    = ent_valid && ent_ready;
    assign ptr_valid = (state_q == PTR);
    assign ptr_value = nnz_total_q;
    assign ptr_row   = row_idx_q;
    assign done      = ptr_valid && (row_idx_q == RW'(ROW_CNT - 1));

    // Next-state logic: accept a row, scan it, then close it with a pointer
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sign_d      = sign_q;
        row_idx_d   = row_idx_q;
        nnz_total_d = nnz_total_q;
`ifndef TNN_CSR_SKIP_EN
        col_d       = col_q;
`endif
        case (state_q)
            IDLE: begin
                if (row_valid) begin
                    mask_d  = row_mask;
                    sign_d  = row_sign;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ent_hs) nnz_total_d = nnz_total_q + PW'(1);
`ifdef TNN_CSR_SKIP_EN
                if (ent_hs) mask_d = mask_q & ~(COL_CNT'(1) << cur_col);
                if (!ent_valid || (ent_hs && cur_last)) state_d = PTR;
`else
                if (!ent_valid || ent_ready) begin
                    if (col_q == CW'(COL_CNT - 1)) begin
                        col_d   = '0;
                        state_d = PTR;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
`endif
            end
            PTR: begin
                state_d = IDLE;
                if (done) begin
                    row_idx_d   = '0;
                    nnz_total_d = '0;
                end else begin
                    row_idx_d = row_idx_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            sign_q      <= '0;
            row_idx_q   <= '0;
            nnz_total_q <= '0;
`ifndef TNN_CSR_SKIP_EN
            col_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sign_q      <= sign_d;
            row_idx_q   <= row_idx_d;
            nnz_total_q <= nnz_total_d;
`ifndef TNN_CSR_SKIP_EN
            col_q       <= col_d;
`endif
        end
    end

endmodule

// File: tb/tb_tnn_csr_encoder.sv
// Testbench for tnn_csr_encoder (COL_CNT=8, ROW_CNT=2), default or TNN_CSR_SKIP_EN build.
module tb_tnn_csr_encoder;

    localparam int COL_CNT = 8;
    localparam int ROW_CNT = 2;
    localparam int CW = 3;
    localparam int PW = 5;
    localparam int RW = 1;
`ifdef TNN_CSR_SKIP_EN
    localparam int LAT_94 = 4, LAT_00 = 2, LAT_STALL = 7;
`else
    localparam int LAT_94 = 9, LAT_00 = 9, LAT_STALL = 12;
`endif

    typedef struct { int col; int sign; int last; } ent_t;
    typedef struct { int value; int row; int dn; } ptr_t;

    logic clk, rst, row_valid, row_ready, ent_valid, ent_ready;
    logic ent_sign, ent_last, ptr_valid, done;
    logic [COL_CNT-1:0] row_mask, row_sign;
    logic [CW-1:0] ent_col;
    logic [PW-1:0] ptr_value;
    logic [RW-1:0] ptr_row;

    int checks = 0, failures = 0, cyc = 0;
    int ptr_count = 0, last_ptr_value = -1, last_ptr_row = -1, last_ptr_done = -1, last_ptr_cyc = -1;
    int stall_cycles = 0, m_nnz = 0, m_row = 0;
    ent_t exp_q[$];
    ent_t log_q[$];
    ptr_t exp_p[$];

    tnn_csr_encoder #(.COL_CNT(COL_CNT), .ROW_CNT(ROW_CNT)) dut (
        .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready),
        .row_mask(row_mask), .row_sign(row_sign), .ent_valid(ent_valid),
        .ent_ready(ent_ready), .ent_col(ent_col), .ent_sign(ent_sign),
        .ent_last(ent_last), .ptr_valid(ptr_valid), .ptr_value(ptr_value),
        .ptr_row(ptr_row), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: a row's CSR entries and end pointer from its mask and signs
    function automatic void model_row(input logic [COL_CNT-1:0] m, input logic [COL_CNT-1:0] s);
        int hi;
        int cnt;
        ptr_t p;
        hi = -1;
        cnt = 0;
        for (int c = 0; c < COL_CNT; c++) if (m[c]) begin hi = c; cnt++; end
        for (int c = 0; c < COL_CNT; c++) if (m[c]) exp_q.push_back('{c, int'(s[c]), int'(c == hi)});
        m_nnz += cnt;
        p = '{m_nnz, m_row, int'(m_row == ROW_CNT - 1)};
        exp_p.push_back(p);
        if (m_row == ROW_CNT - 1) begin m_row = 0; m_nnz = 0; end
        else m_row++;
    endfunction

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_p.delete();
            m_nnz = 0;
            m_row = 0;
        end else begin
            if (ent_valid) begin
                check_output("entry_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check_output("ent_col", int'(ent_col), exp_q[0].col);
                    check_output("ent_sign", int'(ent_sign), exp_q[0].sign);
                    check_output("ent_last", int'(ent_last), exp_q[0].last);
                    if (ent_ready) begin
                        log_q.push_back('{int'(ent_col), int'(ent_sign), int'(ent_last)});
                        void'(exp_q.pop_front());
                    end
                end
                if (!ent_ready) stall_cycles++;
            end
            if (ptr_valid) begin
                check_output("ptr_pending", int'(exp_p.size() > 0), 1);
                check_output("entries_drained", exp_q.size(), 0);
                if (exp_p.size() > 0) begin
                    check_output("ptr_value", int'(ptr_value), exp_p[0].value);
                    check_output("ptr_row", int'(ptr_row), exp_p[0].row);
                    check_output("ptr_done", int'(done), exp_p[0].dn);
                    void'(exp_p.pop_front());
                end
                ptr_count++;
                last_ptr_value = int'(ptr_value);
                last_ptr_row = int'(ptr_row);
                last_ptr_done = int'(done);
                last_ptr_cyc = cyc;
            end else begin
                check_output("done_without_ptr", int'(done), 0);
            end
            if (row_valid && row_ready) model_row(row_mask, row_sign);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one row and return the cycle in which it was accepted
    task automatic apply_stimulus(input logic [7:0] m, input logic [7:0] s, output int t_acc);
        t_acc = -1;
        row_valid = 1'b1;
        row_mask = m;
        row_sign = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (row_ready) begin t_acc = cyc; break; end
        end
        if (t_acc < 0) check_output("row_accept_timeout", int'(row_ready), 1);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        row_mask = 8'($urandom);
        row_sign = 8'($urandom);
    endtask

    // Drive ent_ready through a scan, optionally stalling one column or resetting mid-row
    task automatic scan_row(input int stall_col, input int stall_n, input int rst_after, output int did_rst);
        int n_before;
        n_before = ptr_count;
        did_rst = 0;
        for (int i = 0; i < 60; i++) begin
            ent_ready = 1'b1;
            if (stall_n > 0 && ent_valid && int'(ent_col) == stall_col) begin
                ent_ready = 1'b0;
                stall_n--;
            end
            if (rst_after >= 0 && log_q.size() == rst_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                did_rst = 1;
                break;
            end
            tick();
            if (ptr_count != n_before) break;
        end
        ent_ready = 1'b1;
        if (rst_after < 0) check_output("ptr_seen", ptr_count - n_before, 1);
    endtask

    function automatic void check_log(input int idx, input int col, input int sign, input int last);
        if (idx < log_q.size()) begin
            check_output("log_col", log_q[idx].col, col);
            check_output("log_sign", log_q[idx].sign, sign);
            check_output("log_last", log_q[idx].last, last);
        end else begin
            check_output("log_len", log_q.size(), idx + 1);
        end
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, base, r, n0;
        int sgn[8];
        sgn = '{1, 0, 1, 0, 0, 1, 0, 1};
        rst = 1'b1;
        row_valid = 1'b0;
        row_mask = '0;
        row_sign = '0;
        ent_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // reset values
        check_output("rst_row_ready", int'(row_ready), 1);
        check_output("rst_ent_valid", int'(ent_valid), 0);
        check_output("rst_ent_last", int'(ent_last), 0);
        check_output("rst_ptr_valid", int'(ptr_valid), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_ent_col", int'(ent_col), 0);
        check_output("rst_ptr_value", int'(ptr_value), 0);
        check_output("rst_ptr_row", int'(ptr_row), 0);

        // row 0: three nonzeros
        base = log_q.size();
        apply_stimulus(8'b1001_0100, 8'b1000_0100, t);
        scan_row(-1, 0, -1, r);
        check_log(base, 2, 1, 0);
        check_log(base + 1, 4, 0, 0);
        check_log(base + 2, 7, 1, 1);
        check_output("r0_ptr_value", last_ptr_value, 3);
        check_output("r0_ptr_row", last_ptr_row, 0);
        check_output("r0_done", last_ptr_done, 0);
        check_output("r0_latency", last_ptr_cyc - t, LAT_94);

        // row 1: all zero, closes the matrix
        base = log_q.size();
        apply_stimulus(8'h00, 8'hFF, t);
        scan_row(-1, 0, -1, r);
        check_output("r1_no_entries", log_q.size(), base);
        check_output("r1_ptr_value", last_ptr_value, 3);
        check_output("r1_ptr_row", last_ptr_row, 1);
        check_output("r1_done", last_ptr_done, 1);
        check_output("r1_latency", last_ptr_cyc - t, LAT_00);

        // new matrix, row 0: full row, pointer restarts from zero
        base = log_q.size();
        apply_stimulus(8'hFF, 8'hA5, t);
        scan_row(-1, 0, -1, r);
        for (int c = 0; c < 8; c++) check_log(base + c, c, sgn[c], int'(c == 7));
        check_output("full_ptr_value", last_ptr_value, 8);
        check_output("full_ptr_row", last_ptr_row, 0);

        // row 1: three nonzeros with a 3-cycle stall on column 4
        base = log_q.size();
        stall_cycles = 0;
        apply_stimulus(8'b1001_0100, 8'b1000_0100, t);
        scan_row(4, 3, -1, r);
        check_output("stall_cycles", stall_cycles, 3);
        check_log(base + 1, 4, 0, 0);
        check_output("stall_ptr_value", last_ptr_value, 11);
        check_output("stall_done", last_ptr_done, 1);
        check_output("stall_latency", last_ptr_cyc - t, LAT_STALL);

        // reset after the second entry of a three-nonzero row
        n0 = ptr_count;
        apply_stimulus(8'b1001_0100, 8'b1000_0100, t);
        scan_row(-1, 0, log_q.size() + 2, r);
        check_output("rst_injected", r, 1);
        check_output("rst_mid_row_ready", int'(row_ready), 1);
        check_output("rst_mid_ent_valid", int'(ent_valid), 0);
        repeat (15) tick();
        check_output("rst_no_ptr", ptr_count, n0);

        // following row counts from zero again
        base = log_q.size();
        apply_stimulus(8'b0000_0011, 8'b0000_0001, t);
        scan_row(-1, 0, -1, r);
        check_log(base, 0, 1, 0);
        check_log(base + 1, 1, 0, 1);
        check_output("post_rst_ptr_value", last_ptr_value, 2);
        check_output("post_rst_ptr_row", last_ptr_row, 0);
        check_output("post_rst_latency", last_ptr_cyc - t, LAT_00 == 2 ? 3 : 9);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
